// File: rtl/preg_free_list_pkg.sv
// Shared sizing and checkpoint types for the physical-register free list.
package preg_free_list_pkg;

  localparam int unsigned N_PHYS_REGS_DEF = 64;
  localparam int unsigned N_ARCH_REGS_DEF = 32;
  localparam int unsigned ROB_DEPTH_DEF   = 16;
  localparam int unsigned PREG_W_DEF      = $clog2(N_PHYS_REGS_DEF);
  localparam int unsigned ROB_W_DEF       = $clog2(ROB_DEPTH_DEF);

  typedef logic [PREG_W_DEF:0] fl_ptr_t;

  typedef struct packed {
    fl_ptr_t head;
  } fl_head_snapshot_t;

endpackage

// File: rtl/preg_free_list.sv
// Circular free list of physical registers with per-ROB-tag head checkpoints.
module preg_free_list
  import preg_free_list_pkg::*;
#(
  parameter  int unsigned N_PHYS_REGS = N_PHYS_REGS_DEF,
  parameter  int unsigned N_ARCH_REGS = N_ARCH_REGS_DEF,
  parameter  int unsigned ROB_DEPTH   = ROB_DEPTH_DEF,
  localparam int unsigned PREG_W      = $clog2(N_PHYS_REGS),
  localparam int unsigned ROB_W       = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req_i,
  output logic              alloc_valid_o,
  output logic [PREG_W-1:0] alloc_preg_o,
  output logic              alloc_inval_o,
  output logic [PREG_W-1:0] alloc_inval_preg_o,
  input  logic              free_valid_i,
  input  logic [PREG_W-1:0] free_preg_i,
  input  logic              checkpoint_take_i,
  input  logic [ROB_W-1:0]  checkpoint_tag_i,
  input  logic              recover_i,
  input  logic [ROB_W-1:0]  recover_tag_i,
  input  logic              flush_i,
  output logic [PREG_W:0]   free_count_o
);

  typedef logic [PREG_W:0] ptr_t;

  logic [PREG_W-1:0] fl [0:N_PHYS_REGS-1];
  ptr_t              ckpt [0:ROB_DEPTH-1];
  ptr_t              head, tail, cmt_head;

  ptr_t count;
  logic fire;
  logic do_free;
  logic push;
  ptr_t head_alloc;
  ptr_t cmt_head_next;

  always_comb begin
    count         = tail - head;
    fire          = alloc_req_i && (count != '0) && !recover_i && !flush_i;
    // A free into a full list is illegal; it is dropped so state stays intact.
    do_free       = free_valid_i && (count != ptr_t'(N_PHYS_REGS));
    push          = do_free && (free_preg_i != '0);
    head_alloc    = head + ptr_t'(fire);
    cmt_head_next = cmt_head + ptr_t'(do_free);
  end

  assign alloc_valid_o      = (count != '0);
  assign alloc_preg_o       = fl[head[PREG_W-1:0]];
  assign alloc_inval_o      = fire;
  assign alloc_inval_preg_o = alloc_preg_o;
  assign free_count_o       = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_PHYS_REGS; i++) begin
        fl[i] <= (i < N_PHYS_REGS - N_ARCH_REGS) ? PREG_W'(N_ARCH_REGS + i) : '0;
      end
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        ckpt[i] <= '0;
      end
      head     <= '0;
      cmt_head <= '0;
      tail     <= ptr_t'(N_PHYS_REGS - N_ARCH_REGS);
    end else begin
      if (free_valid_i) begin
        assert (count != ptr_t'(N_PHYS_REGS))
          else $error("preg_free_list: free while list is full");
      end
      if (push) begin
        fl[tail[PREG_W-1:0]] <= free_preg_i;
      end
      tail     <= tail + ptr_t'(push);
      cmt_head <= cmt_head_next;
      if (recover_i) begin
        head <= ckpt[recover_tag_i];
      end else if (flush_i) begin
        head <= cmt_head_next;
      end else begin
        head <= head_alloc;
        if (checkpoint_take_i) begin
          ckpt[checkpoint_tag_i] <= head_alloc;
        end
      end
    end
  end

endmodule
